// File: rtl/vga_sync_gen_pkg.sv
// Shared 640x480@60 raster timing constants.
// Overlay blocks reuse H_DISP/V_DISP for their position checks.
package vga_sync_gen_pkg;

    localparam int CW = 10;

    localparam int H_DISP = 640;
    localparam int H_FP   = 16;
    localparam int H_SYNC = 96;
    localparam int H_BP   = 48;

    localparam int V_DISP = 480;
    localparam int V_FP   = 10;
    localparam int V_SYNC = 2;
    localparam int V_BP   = 33;

    localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;

    function automatic logic in_window(
        input logic [CW-1:0] v,
        input logic [CW-1:0] lo,
        input logic [CW-1:0] hi
    );
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/vga_sync_gen_mod_m_counter.sv
// Modulo-M wrap counter with synchronous clear, count enable and
// a max_tick flag decoded from the registered count.
module mod_m_counter
    import vga_sync_gen_pkg::*;
#(
    parameter int M = 10,
    parameter int W = CW
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] q,
    output logic [W-1:0] q_next,
    output logic         max_tick
);

    localparam logic [W-1:0] LAST = W'(M - 1);

    always_comb begin
        q_next = q;
        if (clr)
            q_next = '0;
        else if (en)
            q_next = (q == LAST) ? '0 : q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            q <= '0;
        else
            q <= q_next;
    end

    assign max_tick = (q == LAST);

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing: pixel tick divider, h/v counters, registered
// syncs, blanking qualifier and a frame_start strobe.
module vga_sync_gen
    import vga_sync_gen_pkg::*;
#(
    parameter int   DIV      = 4,
    parameter int   HD       = H_DISP,
    parameter int   HF       = H_FP,
    parameter int   HS       = H_SYNC,
    parameter int   HB       = H_BP,
    parameter int   VD       = V_DISP,
    parameter int   VF       = V_FP,
    parameter int   VS       = V_SYNC,
    parameter int   VB       = V_BP,
    parameter logic SYNC_ACT = 1'b0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    output logic          p_tick,
    output logic [CW-1:0] pixel_x,
    output logic [CW-1:0] pixel_y,
    output logic          video_on,
    output logic          hsync,
    output logic          vsync,
    output logic          frame_start
);

    localparam int HT = HD + HF + HS + HB;
    localparam int VT = VD + VF + VS + VB;
    localparam int TW = $clog2(DIV);

    localparam logic [CW-1:0] HD_C  = CW'(HD);
    localparam logic [CW-1:0] VD_C  = CW'(VD);
    localparam logic [CW-1:0] HS_LO = CW'(HD + HF);
    localparam logic [CW-1:0] HS_HI = CW'(HD + HF + HS - 1);
    localparam logic [CW-1:0] VS_LO = CW'(VD + VF);
    localparam logic [CW-1:0] VS_HI = CW'(VD + VF + VS - 1);

    logic          tick_max;
    logic          h_max;
    logic          v_max;
    logic [TW-1:0] unused_tick_q;
    logic [TW-1:0] unused_tick_next;
    logic [CW-1:0] h_next;
    logic [CW-1:0] v_next;

    // en low clears every stage so a restart looks exactly like reset
    mod_m_counter #(.M(DIV), .W(TW)) tick_div (
        .clk      (clk),
        .reset    (reset),
        .clr      (~en),
        .en       (1'b1),
        .q        (unused_tick_q),
        .q_next   (unused_tick_next),
        .max_tick (tick_max)
    );

    assign p_tick = en & tick_max;

    mod_m_counter #(.M(HT), .W(CW)) h_cnt (
        .clk      (clk),
        .reset    (reset),
        .clr      (~en),
        .en       (p_tick),
        .q        (pixel_x),
        .q_next   (h_next),
        .max_tick (h_max)
    );

    mod_m_counter #(.M(VT), .W(CW)) v_cnt (
        .clk      (clk),
        .reset    (reset),
        .clr      (~en),
        .en       (p_tick & h_max),
        .q        (pixel_y),
        .q_next   (v_next),
        .max_tick (v_max)
    );

    // syncs decode the next counts so they land on the same edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hsync <= ~SYNC_ACT;
            vsync <= ~SYNC_ACT;
        end else if (!en) begin
            hsync <= ~SYNC_ACT;
            vsync <= ~SYNC_ACT;
        end else begin
            hsync <= in_window(h_next, HS_LO, HS_HI) ? SYNC_ACT : ~SYNC_ACT;
            vsync <= in_window(v_next, VS_LO, VS_HI) ? SYNC_ACT : ~SYNC_ACT;
        end
    end

    assign video_on    = (pixel_x < HD_C) && (pixel_y < VD_C);
    assign frame_start = p_tick & h_max & v_max;

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
Timing generator that drives the pixel_x/pixel_y raster coordinates consumed by every on-screen text and number overlay block. It derives a pixel tick from the system clock and runs horizontal and vertical counters. It produces registered hsync/vsync, a video_on blanking qualifier and a one-cycle frame_start strobe. It sits between the board clock and the pixel-generation mux that feeds the VGA DAC.

Parameters:
DIV, 4, system clocks per pixel (100 MHz -> 25 MHz); legal range 2..16
HD, 640, horizontal display pixels
HF, 16, horizontal front porch
HS, 96, horizontal sync width
HB, 48, horizontal back porch
VD, 480, vertical display lines
VF, 10, vertical front porch
VS, 2, vertical sync width
VB, 33, vertical back porch
SYNC_ACT, 0, active level of hsync/vsync (0 = active-low)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
en  in  1  run enable; low holds raster at origin
p_tick  out  1  one-clk pulse, pixel rate
pixel_x  out  10  current column (h_count)
pixel_y  out  10  current row (v_count)
video_on  out  1  high when pixel_x<HD and pixel_y<VD
hsync  out  1  horizontal sync, registered
vsync  out  1  vertical sync, registered
frame_start  out  1  one-clk pulse, last pixel of frame

Behaviour:
- H_TOTAL=HD+HF+HS+HB (800); V_TOTAL=VD+VF+VS+VB (525). All counters are 10-bit unsigned.
- Reset (async, active-high): tick_cnt=0, h_count=0, v_count=0, hsync=vsync=~SYNC_ACT. Outputs during reset: p_tick=0, frame_start=0, video_on=1 (origin is visible).
- Tick divider:
  - tick_cnt counts 0..DIV-1 and wraps on every clk while en=1.
  - p_tick = en & (tick_cnt==DIV-1), decoded from the register.
  - First p_tick occurs DIV clks after reset deasserts.
- Horizontal counter: on a clk edge with p_tick=1, h_count increments. At H_TOTAL-1 it wraps to 0.
- Vertical counter: advances only when p_tick=1 and h_count==H_TOTAL-1. It increments, and at V_TOTAL-1 it wraps to 0.
- Sync generation:
  - hsync_next = SYNC_ACT when h_next is in [HD+HF, HD+HF+HS-1] (656..751), else ~SYNC_ACT.
  - vsync_next uses the same rule on v_next in [VD+VF, VD+VF+VS-1] (490..491).
  - Syncs register on the same edge as the counters, so they are aligned with pixel_x/pixel_y with zero skew.
- video_on is combinational from the registered counts and has no latency relative to pixel_x/pixel_y.
- frame_start = p_tick & (h_count==H_TOTAL-1) & (v_count==V_TOTAL-1). It is exactly one clk wide, once per frame.
- en=0:
  - On the next edge, tick_cnt, h_count and v_count clear to 0 and syncs go inactive.
  - p_tick and frame_start are low in the same cycle.
  - When en rises, timing restarts exactly as after reset.
- Reset or en drop mid-line or mid-frame: no partial sync pulse survives; the counters restart from the origin.
- Counts never exceed H_TOTAL-1/V_TOTAL-1. An out-of-range state is impossible after reset.

Decomposition:
- Shared package: the 640x480@60 timing constants (HD, HF, HS, HB, VD, VF, VS, VB) and derived H_TOTAL/V_TOTAL, so overlay blocks can use the same HD/VD for position checks.
- One natural sub-module, mod_m_counter: a parameterized wrap counter with enable and a max_tick output. It is instantiated three times: tick divider, h counter, v counter.

Test Plan:
1. Reset released with en=1, DIV=4 -> first p_tick on the 4th clk; p_tick period is 4 clks; pixel_x steps 0,1,2.
2. Run one line -> hsync goes active on the clk where pixel_x becomes 656 and inactive at 752; pixel_x wraps 799->0 and pixel_y goes 0->1 on the same edge.
3. Run one full frame (800*525*4 = 1,680,000 clks) -> vsync is active only for pixel_y 490..491; frame_start pulses once at (799,524); the next frame_start comes 1,680,000 clks later.
4. video_on check -> high at (639,479); low at (640,0), (0,480) and (799,524).
5. Drop en at pixel (300,200) for 10 clks -> p_tick=0, counts read (0,0), syncs inactive; after en rises the first p_tick comes 4 clks later.
6. Assert reset asynchronously mid-hsync at pixel_x=700 (not on a clk edge) -> hsync goes inactive and counts read 0 immediately, without waiting for a clock edge.
